// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA ROM read scheduler.
//   vga_state_e : owner of the ROM read issued in the previous cycle
//   VGA_WIDTH   : default ROM data width in bits
//   VGA_DEPTH   : default ROM depth in words
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int VGA_WIDTH = 8;
    localparam int VGA_DEPTH = 16;

    // The state doubles as the pipeline tag: it names who owns the read
    // whose data returns from the ROM in the current cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DISP = 2'd1,
        ST_HOST = 2'd2
    } vga_state_e;

endpackage

// File: rtl/vga_rom_sched.sv
// ---------------------------------------------------------------------------
// vga_rom_sched
// Arbitrates one single-port ROM between a high-priority display fetch
// requester and a low-priority host/debug requester.  A starvation counter
// forces a host grant after MAX_STARVE consecutive display wins while the
// host is waiting.
//
// Handshake: a requester raises *_req_in with a stable *_addr_in and holds
// both until *_gnt_out is seen high in the same cycle (grant is
// combinational).  Exactly one cycle after its grant, the winner sees
// *_valid_out high for one cycle with *_data_out carrying the ROM word;
// *_data_out is 0 whenever *_valid_out is low.  There is no backpressure on
// the return path.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   disp_req_in/addr_in           display request and address
//   disp_gnt_out/valid_out/data_out  display grant, return valid, data
//   host_req_in/addr_in           host request and address
//   host_gnt_out/valid_out/data_out  host grant, return valid, data
//   rom_rd_en_out/rom_addr_out    ROM read command
//   rom_data_in                   ROM registered read data (1-cycle latency)
//   starve_cnt_out                consecutive display wins while host waits
//   state_out                     FSM state (observability)
// ---------------------------------------------------------------------------
module vga_rom_sched
    import vga_pkg::*;
#(
    parameter int WIDTH      = VGA_WIDTH,
    parameter int DEPTH      = VGA_DEPTH,
    parameter int MAX_STARVE = 4,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             disp_req_in,
    input  logic [AW-1:0]    disp_addr_in,
    output logic             disp_gnt_out,
    output logic             disp_valid_out,
    output logic [WIDTH-1:0] disp_data_out,
    input  logic             host_req_in,
    input  logic [AW-1:0]    host_addr_in,
    output logic             host_gnt_out,
    output logic             host_valid_out,
    output logic [WIDTH-1:0] host_data_out,
    output logic             rom_rd_en_out,
    output logic [AW-1:0]    rom_addr_out,
    input  logic [WIDTH-1:0] rom_data_in,
    output logic [3:0]       starve_cnt_out,
    output logic [1:0]       state_out
);

    localparam logic [3:0] STARVE_LIM = 4'(MAX_STARVE);

    vga_state_e    state_q, state_d;
    logic [3:0]    starve_q, starve_d;
    logic [AW-1:0] addr_q, addr_d;

    logic force_host;
    logic disp_gnt;
    logic host_gnt;

    // Grant, next-state, counter and address selection.
    always_comb begin
        force_host = 1'b0;
        disp_gnt   = 1'b0;
        host_gnt   = 1'b0;
        state_d    = ST_IDLE;
        starve_d   = starve_q;
        addr_d     = addr_q;

        // Host overtakes the display only once it has lost MAX_STARVE times.
        force_host = host_req_in && disp_req_in && (starve_q == STARVE_LIM);
        // Grants are blocked while reset is held so no read leaks out.
        disp_gnt   = !rst && disp_req_in && !force_host;
        host_gnt   = !rst && host_req_in && !disp_gnt;

        if (disp_gnt) begin
            state_d = ST_DISP;
            addr_d  = disp_addr_in;
        end else if (host_gnt) begin
            state_d = ST_HOST;
            addr_d  = host_addr_in;
        end

        if (!host_req_in || host_gnt) begin
            starve_d = 4'd0;
        end else if (disp_gnt && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            starve_q <= 4'd0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
        end
    end

    // Without a grant addr_d equals addr_q, so the ROM address holds.
    assign disp_gnt_out   = disp_gnt;
    assign host_gnt_out   = host_gnt;
    assign rom_rd_en_out  = disp_gnt || host_gnt;
    assign rom_addr_out   = addr_d;

    // Async reset clears state_q at once, which suppresses an in-flight valid.
    assign disp_valid_out = (state_q == ST_DISP);
    assign host_valid_out = (state_q == ST_HOST);
    assign disp_data_out  = disp_valid_out ? rom_data_in : '0;
    assign host_data_out  = host_valid_out ? rom_data_in : '0;

    assign starve_cnt_out = starve_q;
    assign state_out      = state_q;

endmodule

// File: tb/tb_vga_rom_sched.sv
// ---------------------------------------------------------------------------
// tb_vga_rom_sched
// Directed bench for vga_rom_sched with a registered ROM model.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.  ROM content: mem[i] = i + 0x10, except mem[5] = 0xA5.
// ---------------------------------------------------------------------------
module tb_vga_rom_sched;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             disp_req_in = 1'b0;
    logic [AW-1:0]    disp_addr_in = '0;
    logic             disp_gnt_out, disp_valid_out;
    logic [WIDTH-1:0] disp_data_out;
    logic             host_req_in = 1'b0;
    logic [AW-1:0]    host_addr_in = '0;
    logic             host_gnt_out, host_valid_out;
    logic [WIDTH-1:0] host_data_out;
    logic             rom_rd_en_out;
    logic [AW-1:0]    rom_addr_out;
    logic [WIDTH-1:0] rom_data_in;
    logic [3:0]       starve_cnt_out;
    logic [1:0]       state_out;

    int n_pass = 0;
    int n_chk  = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- ROM model (active-low reset from inverted rst) ----------------
    logic [WIDTH-1:0] mem [DEPTH];
    logic             rom_rst_n;
    assign rom_rst_n = ~rst;

    always_ff @(posedge clk or negedge rom_rst_n) begin
        if (!rom_rst_n) rom_data_in <= '0;
        else if (rom_rd_en_out) rom_data_in <= mem[rom_addr_out];
    end

    vga_rom_sched #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_STARVE(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .disp_req_in   (disp_req_in),
        .disp_addr_in  (disp_addr_in),
        .disp_gnt_out  (disp_gnt_out),
        .disp_valid_out(disp_valid_out),
        .disp_data_out (disp_data_out),
        .host_req_in   (host_req_in),
        .host_addr_in  (host_addr_in),
        .host_gnt_out  (host_gnt_out),
        .host_valid_out(host_valid_out),
        .host_data_out (host_data_out),
        .rom_rd_en_out (rom_rd_en_out),
        .rom_addr_out  (rom_addr_out),
        .rom_data_in   (rom_data_in),
        .starve_cnt_out(starve_cnt_out),
        .state_out     (state_out)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    // ---------------- driver ----------------
    // One cycle: apply inputs after the rising edge, return at the falling edge.
    task automatic cyc(input logic r, input logic dr, input logic [AW-1:0] da,
                       input logic hr, input logic [AW-1:0] ha);
        @(posedge clk);
        #1;
        rst          = r;
        disp_req_in  = dr;
        disp_addr_in = da;
        host_req_in  = hr;
        host_addr_in = ha;
        @(negedge clk);
    endtask

    int         exp_s [6] = '{0, 1, 2, 3, 4, 0};
    logic       prev_h;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i + 16);
        mem[5] = 8'hA5;

        // Reset held with both requesting: everything quiet.
        cyc(1'b1, 1'b1, 4'd3, 1'b1, 4'd7);
        check("rst_disp_gnt", 32'(disp_gnt_out), 32'd0);
        check("rst_host_gnt", 32'(host_gnt_out), 32'd0);
        check("rst_rd_en", 32'(rom_rd_en_out), 32'd0);
        check("rst_addr", 32'(rom_addr_out), 32'd0);
        check("rst_valid", 32'({disp_valid_out, host_valid_out}), 32'd0);
        check("rst_data", 32'({disp_data_out, host_data_out}), 32'd0);
        check("rst_starve", 32'(starve_cnt_out), 32'd0);
        check("rst_state", 32'(state_out), 32'd0);

        // Display only, addresses 0,1,2.
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 4'd0);
        check("d0_gnt", 32'(disp_gnt_out), 32'd1);
        check("d0_host_gnt", 32'(host_gnt_out), 32'd0);
        check("d0_rd_en", 32'(rom_rd_en_out), 32'd1);
        check("d0_addr", 32'(rom_addr_out), 32'd0);
        check("d0_valid", 32'(disp_valid_out), 32'd0);
        cyc(1'b0, 1'b1, 4'd1, 1'b0, 4'd0);
        check("d1_valid", 32'(disp_valid_out), 32'd1);
        check("d1_data", 32'(disp_data_out), 32'h10);
        check("d1_addr", 32'(rom_addr_out), 32'd1);
        check("d1_hvalid", 32'(host_valid_out), 32'd0);
        cyc(1'b0, 1'b1, 4'd2, 1'b0, 4'd0);
        check("d2_data", 32'(disp_data_out), 32'h11);
        check("d2_hvalid", 32'(host_valid_out), 32'd0);
        cyc(1'b0, 1'b0, 4'd9, 1'b0, 4'd0);
        check("d3_data", 32'(disp_data_out), 32'h12);
        check("d3_rd_en", 32'(rom_rd_en_out), 32'd0);
        check("d3_addr_hold", 32'(rom_addr_out), 32'd2);
        check("d3_hvalid", 32'(host_valid_out), 32'd0);
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
        check("d4_valid", 32'(disp_valid_out), 32'd0);
        check("d4_data", 32'(disp_data_out), 32'd0);
        check("d4_state", 32'(state_out), 32'd0);

        // Host only, address 5; request dropped right after the grant.
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 4'd5);
        check("h0_gnt", 32'(host_gnt_out), 32'd1);
        check("h0_disp_gnt", 32'(disp_gnt_out), 32'd0);
        check("h0_rd_en", 32'(rom_rd_en_out), 32'd1);
        check("h0_addr", 32'(rom_addr_out), 32'd5);
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
        check("h1_valid", 32'(host_valid_out), 32'd1);
        check("h1_data", 32'(host_data_out), 32'hA5);
        check("h1_rd_en", 32'(rom_rd_en_out), 32'd0);
        check("h1_dvalid", 32'(disp_valid_out), 32'd0);
        check("h1_state", 32'(state_out), 32'd2);
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
        check("h2_valid", 32'(host_valid_out), 32'd0);
        check("h2_data", 32'(host_data_out), 32'd0);
        check("h2_addr_hold", 32'(rom_addr_out), 32'd5);

        // Both requesting continuously: D,D,D,D,H,D with counter 0,1,2,3,4,0.
        prev_h = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b1, 4'd1, 1'b1, 4'd5);
            check($sformatf("sv%0d_host_gnt", i), 32'(host_gnt_out), 32'(i == 4));
            check($sformatf("sv%0d_disp_gnt", i), 32'(disp_gnt_out), 32'(i != 4));
            check($sformatf("sv%0d_starve", i), 32'(starve_cnt_out), 32'(exp_s[i]));
            check($sformatf("sv%0d_addr", i), 32'(rom_addr_out), (i == 4) ? 32'd5 : 32'd1);
            if (i > 0) begin
                check($sformatf("sv%0d_hvalid", i), 32'(host_valid_out), 32'(prev_h));
                check($sformatf("sv%0d_ddata", i), 32'(disp_data_out), prev_h ? 32'd0 : 32'h11);
                check($sformatf("sv%0d_hdata", i), 32'(host_data_out), prev_h ? 32'hA5 : 32'd0);
            end
            prev_h = (i == 4);
        end
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
        check("sv6_dvalid", 32'(disp_valid_out), 32'd1);
        check("sv6_starve", 32'(starve_cnt_out), 32'd1);

        // Host drops after two display wins: counter clears, then restarts.
        cyc(1'b0, 1'b1, 4'd1, 1'b1, 4'd5);
        check("hd_a_starve", 32'(starve_cnt_out), 32'd0);
        cyc(1'b0, 1'b1, 4'd1, 1'b1, 4'd5);
        check("hd_b_starve", 32'(starve_cnt_out), 32'd1);
        cyc(1'b0, 1'b1, 4'd1, 1'b0, 4'd5);
        check("hd_c_starve", 32'(starve_cnt_out), 32'd2);
        check("hd_c_disp_gnt", 32'(disp_gnt_out), 32'd1);
        cyc(1'b0, 1'b1, 4'd1, 1'b1, 4'd5);
        check("hd_d_starve", 32'(starve_cnt_out), 32'd0);
        check("hd_d_disp_gnt", 32'(disp_gnt_out), 32'd1);
        cyc(1'b0, 1'b1, 4'd1, 1'b1, 4'd5);
        check("hd_e_starve", 32'(starve_cnt_out), 32'd1);

        // Reset asserted in the cycle after a display grant.
        cyc(1'b0, 1'b1, 4'd2, 1'b0, 4'd0);
        check("rm_gnt", 32'(disp_gnt_out), 32'd1);
        check("rm_addr", 32'(rom_addr_out), 32'd2);
        cyc(1'b1, 1'b1, 4'd3, 1'b0, 4'd0);
        check("rm_valid", 32'(disp_valid_out), 32'd0);
        check("rm_data", 32'(disp_data_out), 32'd0);
        check("rm_gnt_rst", 32'(disp_gnt_out), 32'd0);
        check("rm_rd_en", 32'(rom_rd_en_out), 32'd0);
        check("rm_addr_rst", 32'(rom_addr_out), 32'd0);
        check("rm_starve", 32'(starve_cnt_out), 32'd0);
        check("rm_state", 32'(state_out), 32'd0);
        cyc(1'b0, 1'b1, 4'd3, 1'b0, 4'd0);
        check("rr_gnt", 32'(disp_gnt_out), 32'd1);
        check("rr_addr", 32'(rom_addr_out), 32'd3);
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
        check("rr_valid", 32'(disp_valid_out), 32'd1);
        check("rr_data", 32'(disp_data_out), 32'h13);

        // Ten idle cycles with wandering (unrequested) addresses.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 4'(i), 1'b0, 4'(15 - i));
            check($sformatf("idle%0d_rd_en", i), 32'(rom_rd_en_out), 32'd0);
            check($sformatf("idle%0d_addr", i), 32'(rom_addr_out), 32'd3);
            check($sformatf("idle%0d_state", i), 32'(state_out), 32'd0);
            check($sformatf("idle%0d_valid", i), 32'({disp_valid_out, host_valid_out}), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_rom_sched.md
VGA_ROM_SCHED -- requirements
Module: vga_rom_sched

Interface
REQ-001 Parameters: WIDTH, default 8, ROM data width in bits.
REQ-002 Parameters: DEPTH, default 16, ROM words; address width AW = $clog2(DEPTH).
REQ-003 Parameters: MAX_STARVE, default 4, maximum consecutive display grants while host waits; range 1..15.
REQ-004 Ports: clk  in  1  sole clock, all logic on rising edge.
REQ-005 Ports: rst  in  1  asynchronous, active-high reset.
REQ-006 Ports: disp_req_in  in  1, disp_addr_in  in  AW, disp_gnt_out  out  1, disp_valid_out  out  1, disp_data_out  out  WIDTH  (display fetch requester, high priority).
REQ-007 Ports: host_req_in  in  1, host_addr_in  in  AW, host_gnt_out  out  1, host_valid_out  out  1, host_data_out  out  WIDTH  (debug/host requester, low priority).
REQ-008 Ports: rom_rd_en_out  out  1, rom_addr_out  out  AW  (ROM read command); rom_data_in  in  WIDTH  (ROM registered read data, 1-cycle latency).
REQ-009 Ports: starve_cnt_out  out  4, current consecutive display-win count while host pending (observability).

Function
REQ-010 Grant SHALL be combinational in the request cycle N: at most one of disp_gnt_out/host_gnt_out high per cycle.
REQ-011 In cycle N with a grant, rom_rd_en_out SHALL be 1 and rom_addr_out SHALL equal the winner's address; with no grant, rom_rd_en_out SHALL be 0 and rom_addr_out SHALL hold its last driven value (registered copy).
REQ-012 Winner's *_valid_out SHALL be high in cycle N+1 only, with *_data_out = rom_data_in; loser's valid SHALL be 0.
REQ-013 *_data_out SHALL be 0 when the corresponding valid is 0.
REQ-014 Fixed priority: display wins when both request, except per REQ-016.
REQ-015 FSM states: IDLE (no grant last cycle), DISP (display granted last cycle), HOST (host granted last cycle); next state = owner of the current grant, IDLE if none.
REQ-016 Starvation counter increments on each display grant while host_req_in=1; when counter equals MAX_STARVE and both request, host SHALL be granted that cycle.
REQ-017 Counter SHALL clear to 0 on any host grant or any cycle with host_req_in=0; it SHALL saturate at MAX_STARVE.
REQ-018 Back-to-back grants SHALL be supported every cycle (full throughput, one read per cycle).
REQ-019 A requester SHALL hold req and addr stable until granted; scheduler behaviour for addr changes while ungranted is don't-care except it SHALL use the address present in the grant cycle.
REQ-020 Request dropped in the grant cycle's successor SHALL not cancel the already-issued read; valid still asserts in N+1.
REQ-021 Address wrap: addresses ≥ DEPTH (when DEPTH is not a power of two) SHALL be passed unmodified; no range checking.

Reset
REQ-022 While rst=1: FSM=IDLE, counter=0, rom_rd_en_out=0, rom_addr_out=0, both gnt=0, both valid=0, both data=0, starve_cnt_out=0.
REQ-023 Reset asserted mid-read (cycle N+1) SHALL suppress that valid; first grant possible in the first clock edge after rst deasserts.
REQ-024 Integration SHALL drive the ROM's active-low reset from the inverted rst.

Structure
REQ-025 Shared package vga_pkg SHALL hold the FSM state enum (IDLE/DISP/HOST) and default WIDTH/DEPTH constants.
REQ-026 Single module; no sub-modules; grant logic combinational, pipeline tag (owner of outstanding read) registered.

Verification
REQ-027 Display only, addresses 0,1,2 consecutive cycles, mem[i]=i+0x10 -> disp_valid cycles 1..3 with data 0x10,0x11,0x12; host_valid never high.
REQ-028 Host only, addr 5, mem[5]=0xA5 -> host_gnt in cycle 0, host_valid cycle 1, data 0xA5, rom_rd_en one cycle.
REQ-029 Both requesting continuously, MAX_STARVE=4 -> grant pattern D,D,D,D,H repeating; starve_cnt_out 0,1,2,3,4,0.
REQ-030 Host request drops after 2 display wins -> counter clears to 0 next cycle; later host request restarts from 0.
REQ-031 rst asserted in cycle N+1 after display grant -> disp_valid_out 0, all outputs reset values; grants resume the cycle after release.
REQ-032 No requests for 10 cycles -> rom_rd_en_out 0 throughout, rom_addr_out stable, FSM IDLE.
